// File: rtl/i2s_tx.sv
// I2S slave transmitter: shifts held stereo pairs onto dout, MSB one bck after each lrck edge.
// Latency: frame_start/underrun one posedge after the lrck fall; backpressure via in_ready = holding empty.
module i2s_tx #(
    parameter int WORD_SIZE = 24
) (
    input  logic                 bck,
    input  logic                 rst_n,
    input  logic                 lrck,
    input  logic [WORD_SIZE-1:0] l_din,
    input  logic [WORD_SIZE-1:0] r_din,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 dout,
    output logic                 frame_start,
    output logic                 underrun
);

    localparam int CW = $clog2(WORD_SIZE);

    typedef enum logic [1:0] {UNSYNC, SHIFT, PAD} state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_lrck_q, r_lrck_q_vld;
    logic                 r_hold_full;
    logic [WORD_SIZE-1:0] r_hold_l, r_hold_r;
    logic [WORD_SIZE-1:0] r_act_l, r_act_r;
    logic [WORD_SIZE-1:0] r_shreg, w_shreg_nxt;
    logic [CW-1:0]        r_bitcnt, w_bitcnt_nxt;
    logic                 w_ws_chg, w_frame, w_accept;
    logic [WORD_SIZE-1:0] w_left_word, w_right_word, w_load_word;

    assign w_ws_chg = r_lrck_q_vld & (lrck != r_lrck_q);
    assign w_frame  = w_ws_chg & ~lrck;
    assign w_accept = in_valid & ~r_hold_full;
    assign in_ready = ~r_hold_full;

    // The left word of a new frame comes straight from holding; the right word uses the
    // copy latched at that frame's left start, so a refill mid-frame never splits a pair.
    assign w_left_word  = r_hold_full ? r_hold_l : '0;
    assign w_right_word = r_act_r;
    assign w_load_word  = lrck ? w_right_word : w_left_word;

    always_comb begin
        w_state_nxt  = r_state;
        w_shreg_nxt  = r_shreg;
        w_bitcnt_nxt = r_bitcnt;
        case (r_state)
            UNSYNC: begin
                w_shreg_nxt = '0;
                if (w_frame) begin
                    w_state_nxt  = SHIFT;
                    w_shreg_nxt  = w_load_word;
                    w_bitcnt_nxt = CW'(WORD_SIZE - 1);
                end
            end
            SHIFT, PAD: begin
                if (w_ws_chg) begin
                    w_state_nxt  = SHIFT;
                    w_shreg_nxt  = w_load_word;
                    w_bitcnt_nxt = CW'(WORD_SIZE - 1);
                end else if (r_state == SHIFT) begin
                    w_shreg_nxt = r_shreg << 1;
                    if (r_bitcnt == '0) begin
                        w_state_nxt = PAD;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt - 1'b1;
                    end
                end else begin
                    w_shreg_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = UNSYNC;
                w_shreg_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge bck or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= UNSYNC;
            r_shreg      <= '0;
            r_bitcnt     <= '0;
            r_lrck_q     <= 1'b0;
            r_lrck_q_vld <= 1'b0;
            r_hold_full  <= 1'b0;
            r_hold_l     <= '0;
            r_hold_r     <= '0;
            r_act_l      <= '0;
            r_act_r      <= '0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shreg      <= w_shreg_nxt;
            r_bitcnt     <= w_bitcnt_nxt;
            r_lrck_q     <= lrck;
            r_lrck_q_vld <= 1'b1;
            frame_start  <= w_frame;
            underrun     <= w_frame & ~r_hold_full;
            if (w_frame) begin
                r_act_l <= w_left_word;
                r_act_r <= r_hold_full ? r_hold_r : '0;
            end
            // A pair offered on the frame-start edge itself lands here only after the frame
            // has already latched zeros: no bypass path.
            if (w_accept) begin
                r_hold_full <= 1'b1;
                r_hold_l    <= l_din;
                r_hold_r    <= r_din;
            end else if (w_frame) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    always_ff @(negedge bck or negedge rst_n) begin
        if (!rst_n) begin
            dout <= 1'b0;
        end else begin
            dout <= r_shreg[WORD_SIZE-1];
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: drives lrck slots and a DSP source, checks every bck against a slot/frame model.
module tb_i2s_tx;
    localparam int W = 24;

    logic         bck = 1'b0;
    logic         rst_n = 1'b0;
    logic         lrck = 1'b1;
    logic [W-1:0] l_din = '0;
    logic [W-1:0] r_din = '0;
    logic         in_valid = 1'b0;
    logic         in_ready, dout, frame_start, underrun;

    i2s_tx #(.WORD_SIZE(W)) dut (
        .bck(bck), .rst_n(rst_n), .lrck(lrck), .l_din(l_din), .r_din(r_din),
        .in_valid(in_valid), .in_ready(in_ready), .dout(dout),
        .frame_start(frame_start), .underrun(underrun)
    );

    always #5 bck = ~bck;

    int checks = 0;
    int failures = 0;

    // Reference model: which pair each frame carries, and where in its slot each bit sits.
    bit           m_held, m_sync, m_prev_lr, m_exp_dout;
    logic [W-1:0] m_hl, m_hr, m_al, m_ar, m_word;
    int           m_pos;
    logic [W-1:0] q_l[$], q_r[$];
    bit           push_en, rand_push;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_held = 0; m_sync = 0; m_exp_dout = 0; m_pos = 0;
        m_hl = '0; m_hr = '0; m_al = '0; m_ar = '0; m_word = '0;
    endtask

    task automatic cycle(input bit lr);
        bit edge_seen, fs, uf, acc;
        @(negedge bck);
        lrck = lr;
        if (!in_valid && push_en) begin
            if (q_l.size() > 0) begin
                l_din = q_l.pop_front();
                r_din = q_r.pop_front();
                in_valid = 1'b1;
            end else if (rand_push && ($urandom_range(0, 3) == 0)) begin
                l_din = W'($urandom);
                r_din = W'($urandom);
                in_valid = 1'b1;
            end
        end
        @(posedge bck);
        #1;
        chk("dout", dout, m_exp_dout);
        edge_seen = (lr != m_prev_lr);
        m_prev_lr = lr;
        fs  = edge_seen && !lr;
        uf  = 0;
        acc = in_valid && !m_held;
        if (fs) begin
            m_sync = 1;
            if (m_held) begin
                m_al = m_hl; m_ar = m_hr; m_held = 0;
            end else begin
                m_al = '0; m_ar = '0; uf = 1;
            end
        end
        if (acc) begin
            m_held = 1; m_hl = l_din; m_hr = r_din;
        end
        if (edge_seen && m_sync) begin
            m_word = lr ? m_ar : m_al;
            m_pos  = 0;
        end else begin
            m_pos++;
        end
        m_exp_dout = (m_sync && m_pos < W) ? m_word[W-1-m_pos] : 1'b0;
        chk("frame_start", frame_start, fs);
        chk("underrun", underrun, uf);
        chk("in_ready", in_ready, !m_held);
        if (acc) in_valid = 1'b0;
    endtask

    task automatic frames(input int slot, input int n);
        for (int f = 0; f < n; f++) begin
            for (int i = 0; i < slot; i++) cycle(1'b0);
            for (int i = 0; i < slot; i++) cycle(1'b1);
        end
    endtask

    task automatic do_reset(input bit rel_lr);
        rst_n = 1'b0;
        in_valid = 1'b0;
        push_en = 0;
        #1;
        chk("rst_dout", dout, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_frame_start", frame_start, 1'b0);
        model_clear();
        repeat (3) @(negedge bck);
        lrck = rel_lr;
        m_prev_lr = rel_lr;
        rst_n = 1'b1;
    endtask

    initial begin
        push_en = 0; rand_push = 0;
        do_reset(1'b1);
        // Unsynced with lrck high: dout stays 0 while a pair is accepted.
        q_l.push_back(24'hA5A5A5); q_r.push_back(24'h5A5A5A);
        push_en = 1;
        repeat (6) cycle(1'b1);
        // Loopback pattern in 32-bit slots, then a frame with nothing held.
        frames(32, 2);
        // Pair offered on the frame-start edge: that frame underruns, the next carries it.
        q_l.push_back(24'h123456); q_r.push_back(24'h89ABCD);
        frames(32, 2);
        // Back-to-back pairs: second waits for the frame that consumes the first.
        q_l.push_back(24'h800001); q_r.push_back(24'h7FFFFE);
        q_l.push_back(24'h0F0F0F); q_r.push_back(24'hF0F0F0);
        repeat (3) cycle(1'b1);
        frames(32, 3);
        // Short slots truncate to the top bits.
        q_l.push_back(24'hFEDCBA); q_r.push_back(24'hC3C3C3);
        repeat (3) cycle(1'b1);
        frames(16, 2);
        // Random traffic over assorted slot lengths.
        rand_push = 1;
        frames(32, 5);
        frames(16, 4);
        frames(24, 3);
        frames(20, 3);
        frames(28, 3);
        // Reset in the middle of a left word.
        q_l.push_back(24'hFFFFFF); q_r.push_back(24'hFFFFFF);
        repeat (3) cycle(1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0);
        do_reset(1'b0);
        // Rising lrck while unsynced must be ignored.
        push_en = 1;
        repeat (5) cycle(1'b0);
        repeat (10) cycle(1'b1);
        frames(32, 3);
        frames(25, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
